tempsens_sequencer: RTL

- Measurement scheduler for the ring-oscillator temperature sensor.
- Gates the edge counter over fixed windows, averages 2^LOG2_N samples, and answers single-byte UART commands by sending the 16-bit result.
- Sits between the UART core (rx/tx byte handshakes) and the counter; replaces ad-hoc sequencing of counter, averager and transmitter.

---
 rtl/tempsens_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/tempsens_sequencer.sv
// rtl/tempsens_sequencer.sv - ring-oscillator temperature sensor measurement scheduler
// Optional TEMPSENS_CHECKSUM_EN appends an XOR checksum byte to every reply.
module tempsens_sequencer #(
  parameter int WIDTH         = 16,
  parameter int WINDOW_CYCLES = 1000,
  parameter int SETTLE_CYCLES = 2,
  parameter int LOG2_N        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             rx_ready,
  input  logic [7:0]       rx_data,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             cnt_clr,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             ovf
);

  localparam int CW = $clog2((WINDOW_CYCLES > SETTLE_CYCLES ? WINDOW_CYCLES : SETTLE_CYCLES) + 1);
  localparam int AW = WIDTH + LOG2_N;

  localparam logic [CW-1:0]     WIN_LAST  = CW'(WINDOW_CYCLES - 1);
  localparam logic [CW-1:0]     SET_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [LOG2_N:0]   SAMP_LAST = (LOG2_N + 1)'((1 << LOG2_N) - 1);
  localparam logic [WIDTH-1:0]  ALL_ONES  = {WIDTH{1'b1}};

  localparam logic [7:0] CMD_M = 8'h4D;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_S = 8'h53;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CLEAR   = 4'd1;
  localparam logic [3:0] S_WINDOW  = 4'd2;
  localparam logic [3:0] S_SETTLE  = 4'd3;
  localparam logic [3:0] S_SAMPLE  = 4'd4;
  localparam logic [3:0] S_DONE    = 4'd5;
  localparam logic [3:0] S_SEND_LO = 4'd6;
  localparam logic [3:0] S_WAIT_LO = 4'd7;
  localparam logic [3:0] S_SEND_HI = 4'd8;
  localparam logic [3:0] S_WAIT_HI = 4'd9;
`ifdef TEMPSENS_CHECKSUM_EN
  localparam logic [3:0] S_SEND_CK = 4'd10;
  localparam logic [3:0] S_WAIT_CK = 4'd11;
`endif

  logic [3:0]       state;
  logic [CW-1:0]    cyc;
  logic [LOG2_N:0]  nsamp;
  logic [AW-1:0]    acc;
  logic             send_after;
  logic             wait_first;

  logic [WIDTH-1:0] avg;
  logic [15:0]      avg16;
  logic [15:0]      reply16;

  // Replies carry zeros until a measurement has completed.
  assign avg     = WIDTH'(acc >> LOG2_N);
  assign avg16   = 16'(avg);
  assign reply16 = 16'(result_valid ? result : {WIDTH{1'b0}});

  assign cnt_en   = (state == S_WINDOW);
  assign cnt_clr  = (state == S_CLEAR);
  assign busy     = (state != S_IDLE);
`ifdef TEMPSENS_CHECKSUM_EN
  assign tx_start = (state == S_SEND_LO) || (state == S_SEND_HI) || (state == S_SEND_CK);
`else
  assign tx_start = (state == S_SEND_LO) || (state == S_SEND_HI);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cyc          <= '0;
      nsamp        <= '0;
      acc          <= '0;
      send_after   <= 1'b0;
      wait_first   <= 1'b0;
      tx_data      <= 8'h00;
      result       <= '0;
      result_valid <= 1'b0;
      ovf          <= 1'b0;
    end else if (!en && (state != S_IDLE)) begin
      state      <= S_IDLE;
      wait_first <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en && rx_ready) begin
            case (rx_data)
              CMD_M, CMD_S: begin
                state        <= S_CLEAR;
                acc          <= '0;
                nsamp        <= '0;
                ovf          <= 1'b0;
                result_valid <= 1'b0;
                send_after   <= (rx_data == CMD_S);
              end
              CMD_R: begin
                // A send may only begin while the transmitter is idle.
                if (!tx_busy) begin
                  state   <= S_SEND_LO;
                  tx_data <= reply16[7:0];
                end
              end
              default: ;
            endcase
          end
        end
        S_CLEAR: begin
          state <= S_WINDOW;
          cyc   <= '0;
        end
        S_WINDOW: begin
          if (cyc == WIN_LAST) begin
            cyc   <= '0;
            state <= S_SETTLE;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cyc == SET_LAST) state <= S_SAMPLE;
          else                 cyc   <= cyc + 1'b1;
        end
        S_SAMPLE: begin
          acc   <= acc + AW'(count);
          nsamp <= nsamp + 1'b1;
          if (count == ALL_ONES) ovf <= 1'b1;
          state <= (nsamp == SAMP_LAST) ? S_DONE : S_CLEAR;
        end
        S_DONE: begin
          // Held here while tx is busy; reloading the same average is harmless.
          result       <= avg;
          result_valid <= 1'b1;
          if (!send_after) begin
            state <= S_IDLE;
          end else if (!tx_busy) begin
            state   <= S_SEND_LO;
            tx_data <= avg16[7:0];
          end
        end
        S_SEND_LO: begin
          state      <= S_WAIT_LO;
          wait_first <= 1'b1;
        end
        S_WAIT_LO: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!tx_busy) begin
            state   <= S_SEND_HI;
            tx_data <= reply16[15:8];
          end
        end
        S_SEND_HI: begin
          state      <= S_WAIT_HI;
          wait_first <= 1'b1;
        end
        S_WAIT_HI: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!tx_busy) begin
`ifdef TEMPSENS_CHECKSUM_EN
            state   <= S_SEND_CK;
            tx_data <= reply16[7:0] ^ reply16[15:8];
`else
            state <= S_IDLE;
`endif
          end
        end
`ifdef TEMPSENS_CHECKSUM_EN
        S_SEND_CK: begin
          state      <= S_WAIT_CK;
          wait_first <= 1'b1;
        end
        S_WAIT_CK: begin
          if (wait_first)    wait_first <= 1'b0;
          else if (!tx_busy) state      <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
